modbus_frame_tx: RTL
====================

Name: modbus_frame_tx

Overview:
- Frame-level transmitter that sits directly upstream of the UART byte transmitter.
- On a start pulse it reads an N-byte Modbus RTU response (address..data, no CRC) from an external synchronous buffer.
- It computes CRC-16/MODBUS over those bytes and feeds them one at a time to the byte transmitter, then appends the CRC (low byte first).
- It finally enforces the t3.5 inter-frame silence before reporting completion.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line baud rate. Must match the byte transmitter. CLK_FREQ/BAUD_RATE >= 16 is required.
- T35_CLKS, (BAUD_RATE > 19200) ? (CLK_FREQ/4000)*7 : (CLK_FREQ/BAUD_RATE)*39, inter-frame silence in clocks (203112 at defaults).

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  reset, asynchronous, active-low
- frame_start  input  1  1-cycle pulse, start sending a frame
- frame_len  input  8  payload byte count excluding CRC, sampled with frame_start
- busy  output  1  high from the cycle after an accepted frame_start until frame_done
- frame_done  output  1  1-cycle pulse after the t3.5 gap completes
- buf_rd_en  output  1  buffer read strobe
- buf_rd_addr  output  8  buffer read address, 0..frame_len-1
- buf_rd_data  input  8  buffer data, valid the cycle after buf_rd_en
- tx_start  output  1  to byte transmitter (rising-edge triggered)
- tx_data  output  8  byte to byte transmitter
- tx_state  input  1  byte transmitter busy
- tx_done  input  1  byte transmitter 1-cycle done pulse

Behaviour:
- Clock and reset: clock clk_in; reset rst_n_in, asynchronous, active-low.
- Reset values: busy=0, frame_done=0, buf_rd_en=0, buf_rd_addr=0, tx_start=0, tx_data=0x00, crc=0xFFFF, state=IDLE. Reset mid-frame aborts immediately; no frame_done is issued.
- States: IDLE, FETCH, LOAD, START, WAIT, CRC_LO, CRC_HI, GAP, DONE.
- IDLE:
  - frame_start=1 with frame_len!=0 latches len, clears idx=0, crc=0xFFFF, then goes to FETCH.
  - frame_len==0 is ignored and the block stays IDLE.
  - frame_start is ignored in every state other than IDLE.
- FETCH: buf_rd_en=1 for exactly 1 cycle, buf_rd_addr=idx. Go to LOAD.
- LOAD: capture buf_rd_data into tx_data, start serial CRC update on this byte, go to START. tx_start therefore rises 3 cycles after the frame_start edge.
- START: tx_start=1. Hold until tx_state==1 is sampled, then drive tx_start=0 and go to WAIT.
- Stability rule: tx_data stays stable from LOAD until the next LOAD or CRC state. tx_start is low at all times outside START.
- WAIT: wait for tx_done=1. Then:
  - if idx < len-1: idx+1, go to FETCH;
  - otherwise go to CRC_LO.
- CRC engine:
  - crc ^= byte, then 8 cycles of: crc[0] ? (crc>>1)^0xA001 : crc>>1, one bit per cycle with a 3-bit counter.
  - It runs concurrently with START/WAIT and always finishes before tx_done, guaranteed by CLK_FREQ/BAUD_RATE >= 16.
  - CRC bytes are not folded into the CRC.
- CRC_LO: tx_data=crc[7:0], START/WAIT handshake as above, then CRC_HI.
- CRC_HI: tx_data=crc[15:8], same handshake, then GAP.
- GAP: counter counts T35_CLKS cycles from the cycle after the final tx_done, then DONE.
- DONE: frame_done=1 for 1 cycle, busy=0 in that same cycle, then IDLE.
- Edge cases:
  - frame_len=255 gives addresses 0..254, no wrap.
  - If tx_done coincides with the entry to START, it is not treated as the current byte's done. Only tx_done sampled in WAIT counts.

Test Plan:
- frame_start, len=6, buffer 01 03 00 00 00 01 -> line carries 01 03 00 00 00 01 84 0A; frame_done once, exactly T35_CLKS after the last tx_done.
- len=6, buffer 11 03 00 6B 00 03 -> CRC bytes 76 87 appended; buf_rd_addr sequence 0..5, one buf_rd_en per byte.
- frame_len=0 pulse -> busy stays 0, no buf_rd_en, no tx_start.
- Second frame_start while busy (len=1, byte 0x55) -> ignored; exactly 3 bytes sent, single frame_done.
- Reset asserted during byte 3 -> all outputs reach reset values asynchronously, no frame_done. The next frame sends correctly with the CRC restarted at 0xFFFF.
- Back-to-back frames, second frame_start the cycle after frame_done -> tx_start rises 3 cycles later. No tx_start edge appears during GAP.

Source files
------------

// File: rtl/modbus_frame_tx_if.sv
// Frame transmitter bus bundle.
// Groups the frame request/status signals, the external buffer read port and
// the byte-transmitter handshake into one interface.
//   master : the frame transmitter (drives busy, frame_done, buf_rd_*, tx_start, tx_data)
//   slave  : the surrounding system (drives frame_start, frame_len, buf_rd_data, tx_state, tx_done)
`timescale 1ns/1ps
interface modbus_frame_tx_if;
  logic       frame_start;
  logic [7:0] frame_len;
  logic       busy;
  logic       frame_done;
  logic       buf_rd_en;
  logic [7:0] buf_rd_addr;
  logic [7:0] buf_rd_data;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_state;
  logic       tx_done;

  modport master (
    input  frame_start, frame_len, buf_rd_data, tx_state, tx_done,
    output busy, frame_done, buf_rd_en, buf_rd_addr, tx_start, tx_data
  );

  modport slave (
    output frame_start, frame_len, buf_rd_data, tx_state, tx_done,
    input  busy, frame_done, buf_rd_en, buf_rd_addr, tx_start, tx_data
  );
endinterface

// File: rtl/modbus_frame_tx.sv
// Modbus RTU frame transmitter.
// On frame_start it reads frame_len payload bytes from a synchronous buffer,
// hands each one to the UART byte transmitter, computes CRC-16/MODBUS on the
// fly, appends the CRC (low byte first) and then holds t3.5 of line silence
// before pulsing frame_done.
// Ports:
//   clk_in    system clock
//   rst_n_in  asynchronous active-low reset
//   bus       modbus_frame_tx_if.master: frame_start/frame_len/busy/frame_done,
//             buf_rd_en/buf_rd_addr/buf_rd_data, tx_start/tx_data/tx_state/tx_done
`timescale 1ns/1ps
module modbus_frame_tx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int T35_CLKS  = (BAUD_RATE > 19200) ? (CLK_FREQ / 4000) * 7
                                                : (CLK_FREQ / BAUD_RATE) * 39
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  modbus_frame_tx_if.master bus
);

  // The gap counter runs 0..T35_CLKS-2; the DONE cycle itself is the last
  // silent clock, so frame_done lands exactly T35_CLKS after the final tx_done.
  localparam int               GAP_W    = (T35_CLKS > 2) ? $clog2(T35_CLKS) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(T35_CLKS - 2);

  typedef enum logic [3:0] {
    IDLE, FETCH, LOAD, START, WAIT, CRC_LO, CRC_HI, GAP, DONE
  } state_t;

  // Which byte the shared START/WAIT handshake is currently sending.
  typedef enum logic [1:0] {PH_DATA, PH_CRC_LO, PH_CRC_HI} phase_t;

  state_t           state;
  phase_t           phase;
  logic [7:0]       len;
  logic [7:0]       idx;
  logic [15:0]      crc;
  logic             crc_run;
  logic [2:0]       crc_bit;
  logic [GAP_W-1:0] gap_cnt;

  // NOTE: all state lives in one clocked block with non-blocking assignments,
  // so every register samples the pre-edge values and ordering inside the
  // block cannot create races.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state           <= IDLE;
      phase           <= PH_DATA;
      len             <= '0;
      idx             <= '0;
      crc             <= 16'hFFFF;
      crc_run         <= 1'b0;
      crc_bit         <= '0;
      gap_cnt         <= '0;
      bus.busy        <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.buf_rd_en   <= 1'b0;
      bus.buf_rd_addr <= '0;
      bus.tx_start    <= 1'b0;
      bus.tx_data     <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.frame_done <= 1'b0;
          if (bus.frame_start && bus.frame_len != 8'd0) begin
            len             <= bus.frame_len;
            idx             <= '0;
            crc             <= 16'hFFFF;
            bus.busy        <= 1'b1;
            bus.buf_rd_en   <= 1'b1;
            bus.buf_rd_addr <= '0;
            state           <= FETCH;
          end
        end

        // Read strobe is already high for this single cycle; data returns in LOAD.
        FETCH: begin
          bus.buf_rd_en <= 1'b0;
          state         <= LOAD;
        end

        LOAD: begin
          bus.tx_data  <= bus.buf_rd_data;
          crc          <= crc ^ {8'h00, bus.buf_rd_data};
          crc_run      <= 1'b1;
          crc_bit      <= '0;
          phase        <= PH_DATA;
          bus.tx_start <= 1'b1;
          state        <= START;
        end

        // tx_done is deliberately ignored here: only a done seen in WAIT
        // belongs to the byte just started.
        START: begin
          if (bus.tx_state) begin
            bus.tx_start <= 1'b0;
            state        <= WAIT;
          end
        end

        WAIT: begin
          if (bus.tx_done) begin
            case (phase)
              PH_DATA: begin
                if (idx != len - 8'd1) begin
                  idx             <= idx + 8'd1;
                  bus.buf_rd_en   <= 1'b1;
                  bus.buf_rd_addr <= idx + 8'd1;
                  state           <= FETCH;
                end else begin
                  state <= CRC_LO;
                end
              end
              PH_CRC_LO: state <= CRC_HI;
              PH_CRC_HI: begin
                gap_cnt <= '0;
                state   <= GAP;
              end
              default: state <= IDLE;
            endcase
          end
        end

        CRC_LO: begin
          bus.tx_data  <= crc[7:0];
          phase        <= PH_CRC_LO;
          bus.tx_start <= 1'b1;
          state        <= START;
        end

        CRC_HI: begin
          bus.tx_data  <= crc[15:8];
          phase        <= PH_CRC_HI;
          bus.tx_start <= 1'b1;
          state        <= START;
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            bus.frame_done <= 1'b1;
            bus.busy       <= 1'b0;
            state          <= DONE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        DONE: begin
          bus.frame_done <= 1'b0;
          state          <= IDLE;
        end

        default: state <= IDLE;
      endcase

      // Bit-serial CRC: one shift per clock for 8 clocks after each LOAD.
      // A byte on the line lasts far longer than 8 clocks, so the result is
      // settled before the next LOAD or the CRC_LO read.
      if (crc_run) begin
        crc     <= crc[0] ? ((crc >> 1) ^ 16'hA001) : (crc >> 1);
        crc_bit <= crc_bit + 3'd1;
        if (crc_bit == 3'd7) crc_run <= 1'b0;
      end
    end
  end

endmodule
